// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the multi-context AES keystream scheduler.
// Register offsets, soft-register bus bundles and the issue bundle.
package aes_sched_pkg;

  localparam int NUM_CTX  = 4;
  localparam int CREDITS  = 32;
  localparam int CTX_W    = $clog2(NUM_CTX);
  localparam int CREDIT_W = 7;
  localparam int WORDS_W  = 34;
  localparam int SEQ_W    = 32;
  localparam int ISSUED_W = 48;
  localparam int KEY_W    = 256;

  localparam logic [2:0] REG_KEY0   = 3'd0;
  localparam logic [2:0] REG_KEY1   = 3'd1;
  localparam logic [2:0] REG_KEY2   = 3'd2;
  localparam logic [2:0] REG_KEY3   = 3'd3;
  localparam logic [2:0] REG_WORDS  = 3'd4;
  localparam logic [2:0] REG_ISSUED = 3'd5;
  localparam logic [2:0] REG_STAT   = 3'd6;
  localparam logic [2:0] REG_CLR    = 3'd7;

  localparam logic [CREDIT_W-1:0] CREDIT_MAX =
    CREDIT_W'(CREDITS);

  typedef struct packed {
    logic        valid;
    logic        isWrite;
    logic [31:0] addr;
    logic [63:0] data;
  } SoftRegReq;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } SoftRegResp;

  typedef struct packed {
    logic [CTX_W-1:0] ctx;
    logic [SEQ_W-1:0] seq;
    logic [KEY_W-1:0] key;
  } aes_issue_t;

  function automatic logic [63:0] stat_word(
    input logic                ovf,
    input logic                kerr,
    input logic [CREDIT_W-1:0] credit
  );
    return 64'({ovf, kerr, credit});
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the caller owns the pointer register.
// Search starts at ptr and wraps; N must be a power of two.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int W = $clog2(N);

  logic         w_found;
  logic [W-1:0] w_idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = ptr + W'(i);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        gnt_idx = w_idx;
      end
    end
    if (w_found) gnt = N'(1) << gnt_idx;
  end

endmodule

// File: rtl/aes_ctx_sched.sv
// Time-shares one AES-256 keystream pipeline between tenant contexts.
// Per-context key/words/seq/credit state, round-robin issue, credit return.
module aes_ctx_sched
  import aes_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  SoftRegReq          softreg_req,
  output SoftRegResp         softreg_resp,
  input  logic               issue_ready,
  output logic               issue_valid,
  output logic [CTX_W-1:0]   issue_ctx,
  output logic [SEQ_W-1:0]   issue_seq,
  output logic [KEY_W-1:0]   issue_key,
  input  logic               consume_valid,
  input  logic [CTX_W-1:0]   consume_ctx,
  output logic [NUM_CTX-1:0] busy
);

  logic [KEY_W-1:0]    r_key    [NUM_CTX];
  logic [WORDS_W-1:0]  r_words  [NUM_CTX];
  logic [SEQ_W-1:0]    r_seq    [NUM_CTX];
  logic [ISSUED_W-1:0] r_issued [NUM_CTX];
  logic [CREDIT_W-1:0] r_credit [NUM_CTX];
  logic [NUM_CTX-1:0]  r_err_ovf;
  logic [NUM_CTX-1:0]  r_err_key;
  logic [CTX_W-1:0]    r_rr_ptr;
  logic                r_iss_valid;
  aes_issue_t          r_iss;
  SoftRegResp          r_resp;

  logic               w_map;
  logic               w_wr;
  logic               w_rd;
  logic [CTX_W-1:0]   w_rctx;
  logic [2:0]         w_reg;
  logic [NUM_CTX-1:0] w_sel;
  logic [NUM_CTX-1:0] w_words_wr;
  logic [NUM_CTX-1:0] w_key_wr;
  logic [NUM_CTX-1:0] w_clr_wr;
  logic [NUM_CTX-1:0] w_busy;
  logic [NUM_CTX-1:0] w_req;
  logic [NUM_CTX-1:0] w_cons;
  logic [NUM_CTX-1:0] w_gnt;
  logic [CTX_W-1:0]   w_gnt_idx;
  logic               w_any;
  logic [63:0]        w_rdata;

  assign w_reg  = softreg_req.addr[5:3];
  assign w_rctx = softreg_req.addr[6 +: CTX_W];
  assign w_map  = !softreg_req.addr[8] &&
                  ((softreg_req.addr >> (6 + CTX_W)) == 32'd0);
  assign w_wr   = softreg_req.valid && softreg_req.isWrite && w_map;
  assign w_rd   = softreg_req.valid && !softreg_req.isWrite;

  // A words reload masks that context's request so the reload wins.
  always_comb begin
    for (int c = 0; c < NUM_CTX; c++) begin
      w_sel[c]      = (w_rctx == CTX_W'(c));
      w_words_wr[c] = w_wr && w_sel[c] && (w_reg == REG_WORDS);
      w_key_wr[c]   = w_wr && w_sel[c] && !w_reg[2];
      w_clr_wr[c]   = w_wr && w_sel[c] && (w_reg == REG_CLR);
      w_busy[c]     = (r_words[c] != '0) ||
                      (r_credit[c] != CREDIT_MAX);
      w_req[c]      = issue_ready && (r_words[c] != '0) &&
                      (r_credit[c] != '0) && !w_words_wr[c];
      w_cons[c]     = consume_valid &&
                      (consume_ctx == CTX_W'(c));
    end
  end

  rr_arbiter #(
    .N(NUM_CTX)
  ) u_arb (
    .req     (w_req),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_any = |w_gnt;

  always_comb begin
    w_rdata = '0;
    if (w_map) begin
      case (w_reg)
        REG_WORDS:  w_rdata = 64'(r_words[w_rctx]);
        REG_ISSUED: w_rdata = 64'(r_issued[w_rctx]);
        REG_STAT:   w_rdata = stat_word(r_err_ovf[w_rctx],
                                        r_err_key[w_rctx],
                                        r_credit[w_rctx]);
        default:    w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CTX; c++) begin
        r_key[c]    <= '0;
        r_words[c]  <= '0;
        r_seq[c]    <= '0;
        r_issued[c] <= '0;
        r_credit[c] <= CREDIT_MAX;
      end
      r_err_ovf <= '0;
      r_err_key <= '0;
    end else begin
      for (int c = 0; c < NUM_CTX; c++) begin
        if (w_words_wr[c]) begin
          r_words[c] <= softreg_req.data[WORDS_W-1:0];
          r_seq[c]   <= '0;
        end else if (w_gnt[c]) begin
          r_words[c] <= r_words[c] - 1'b1;
          r_seq[c]   <= r_seq[c] + 1'b1;
        end
        if (w_gnt[c])
          r_issued[c] <= r_issued[c] + 1'b1;
        if (w_clr_wr[c]) begin
          r_err_ovf[c] <= 1'b0;
          r_err_key[c] <= 1'b0;
        end
        // Keys stay frozen while any block of this context is in flight.
        if (w_key_wr[c]) begin
          if (w_busy[c])
            r_err_key[c] <= 1'b1;
          else
            r_key[c][{w_reg[1:0], 6'b0} +: 64] <=
              softreg_req.data;
        end
        if (w_gnt[c] && !w_cons[c]) begin
          r_credit[c] <= r_credit[c] - 1'b1;
        end else if (!w_gnt[c] && w_cons[c]) begin
          if (r_credit[c] == CREDIT_MAX)
            r_err_ovf[c] <= 1'b1;
          else
            r_credit[c] <= r_credit[c] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_iss_valid <= 1'b0;
      r_iss       <= '0;
      r_resp      <= '0;
    end else begin
      r_iss_valid <= w_any;
      if (w_any) begin
        r_rr_ptr <= w_gnt_idx + 1'b1;
        r_iss    <= '{ctx: w_gnt_idx,
                      seq: r_seq[w_gnt_idx],
                      key: r_key[w_gnt_idx]};
      end
      r_resp.valid <= w_rd;
      r_resp.data  <= w_rd ? w_rdata : '0;
    end
  end

  assign issue_valid  = r_iss_valid;
  assign issue_ctx    = r_iss.ctx;
  assign issue_seq    = r_iss.seq;
  assign issue_key    = r_iss.key;
  assign softreg_resp = r_resp;
  assign busy         = w_busy;

endmodule

// File: tb/tb_aes_ctx_sched.sv
// Directed self-checking bench for aes_ctx_sched.
// Linear step sequence; every check is an immediate assertion.
module tb_aes_ctx_sched;
  import aes_sched_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  SoftRegReq          req;
  SoftRegResp         resp;
  logic               issue_ready;
  logic               issue_valid;
  logic [CTX_W-1:0]   issue_ctx;
  logic [SEQ_W-1:0]   issue_seq;
  logic [KEY_W-1:0]   issue_key;
  logic               consume_valid;
  logic [CTX_W-1:0]   consume_ctx;
  logic [NUM_CTX-1:0] busy;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] K0 = 64'h0011223344556677;
  localparam logic [63:0] K1 = 64'h8899aabbccddeeff;
  localparam logic [63:0] K2 = 64'h0123456789abcdef;
  localparam logic [63:0] K3 = 64'hfedcba9876543210;

  logic [255:0] key_full;
  logic [255:0] key_c0;
  logic [255:0] key_c2;
  logic [63:0]  rdv;
  int           cnt;

  aes_ctx_sched dut (
    .clk           (clk),
    .rst           (rst),
    .softreg_req   (req),
    .softreg_resp  (resp),
    .issue_ready   (issue_ready),
    .issue_valid   (issue_valid),
    .issue_ctx     (issue_ctx),
    .issue_seq     (issue_seq),
    .issue_key     (issue_key),
    .consume_valid (consume_valid),
    .consume_ctx   (consume_ctx),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wr(input int c, input int r,
                    input logic [63:0] d);
    req.valid   = 1'b1;
    req.isWrite = 1'b1;
    req.addr    = 32'((c << 6) | (r << 3));
    req.data    = d;
    step();
    req = '0;
  endtask

  task automatic rd_addr(input logic [31:0] a,
                         output logic [63:0] d);
    req.valid   = 1'b1;
    req.isWrite = 1'b0;
    req.addr    = a;
    req.data    = '0;
    step();
    req = '0;
    chk("resp_valid", 256'(resp.valid), 256'(1));
    d = resp.data;
  endtask

  task automatic rd(input int c, input int r,
                    output logic [63:0] d);
    rd_addr(32'((c << 6) | (r << 3)), d);
  endtask

  task automatic chk_iss(input string tag, input int c,
                         input int s, input logic [255:0] k);
    chk({tag, "_valid"}, 256'(issue_valid), 256'(1));
    chk({tag, "_ctx"}, 256'(issue_ctx), 256'(c));
    chk({tag, "_seq"}, 256'(issue_seq), 256'(s));
    chk({tag, "_key"}, issue_key, k);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    issue_ready   = 1'b0;
    consume_valid = 1'b0;
    req           = '0;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    key_full = {K3, K2, K1, K0};
    key_c0   = 256'(64'hAAAA) << 64;
    key_c2   = 256'(64'hBBBB) << 128;
    rst           = 1'b1;
    req           = '0;
    issue_ready   = 1'b0;
    consume_valid = 1'b0;
    consume_ctx   = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_issue_valid", 256'(issue_valid), 256'(0));
    chk("rst_issue_key", issue_key, 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_resp_valid", 256'(resp.valid), 256'(0));
    rd(0, 6, rdv);
    chk("rst_stat", 256'(rdv), 256'(32));

    // 1: single context, three words
    wr(0, 0, K0);
    wr(0, 1, K1);
    wr(0, 2, K2);
    wr(0, 3, K3);
    wr(0, 4, 64'd3);
    issue_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_iss("t1_iss", 0, i, key_full);
    end
    step();
    chk("t1_idle", 256'(issue_valid), 256'(0));
    rd(0, 6, rdv);
    chk("t1_credit", 256'(rdv), 256'(29));
    rd(0, 4, rdv);
    chk("t1_words", 256'(rdv), 256'(0));
    rd(0, 5, rdv);
    chk("t1_issued", 256'(rdv), 256'(3));
    rd_addr(32'h100 | 32'(6 << 3), rdv);
    chk("t1_unmapped", 256'(rdv), 256'(0));

    // 2: two active contexts alternate
    do_reset();
    wr(0, 1, 64'hAAAA);
    wr(2, 2, 64'hBBBB);
    wr(0, 4, 64'd4);
    wr(2, 4, 64'd4);
    issue_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i % 2 == 0)
        chk_iss("t2_iss", 0, i / 2, key_c0);
      else
        chk_iss("t2_iss", 2, i / 2, key_c2);
    end
    step();
    chk("t2_idle", 256'(issue_valid), 256'(0));

    // 3: credit exhaustion and one-credit return
    do_reset();
    wr(1, 3, K3);
    wr(1, 4, 64'd40);
    issue_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      chk("t3_valid", 256'(issue_valid), 256'(1));
      chk("t3_seq", 256'(issue_seq), 256'(i));
    end
    step();
    chk("t3_stall", 256'(issue_valid), 256'(0));
    rd(1, 6, rdv);
    chk("t3_credit0", 256'(rdv), 256'(0));
    rd(1, 4, rdv);
    chk("t3_words", 256'(rdv), 256'(8));
    consume_valid = 1'b1;
    consume_ctx   = 2'd1;
    step();
    consume_valid = 1'b0;
    chk("t3_c1", 256'(issue_valid), 256'(0));
    step();
    chk_iss("t3_after", 1, 32, 256'(K3) << 192);
    step();
    chk("t3_c3", 256'(issue_valid), 256'(0));

    // 4: grant+consume at credit 5, overflow on idle ctx
    do_reset();
    wr(0, 4, 64'd40);
    issue_ready = 1'b1;
    repeat (27) step();
    issue_ready = 1'b0;
    rd(0, 6, rdv);
    chk("t4_credit5", 256'(rdv), 256'(5));
    issue_ready   = 1'b1;
    consume_valid = 1'b1;
    consume_ctx   = 2'd0;
    step();
    issue_ready   = 1'b0;
    consume_valid = 1'b0;
    chk("t4_granted", 256'(issue_valid), 256'(1));
    rd(0, 6, rdv);
    chk("t4_same", 256'(rdv), 256'(5));
    consume_valid = 1'b1;
    consume_ctx   = 2'd3;
    step();
    consume_valid = 1'b0;
    rd(3, 6, rdv);
    chk("t4_ovf", 256'(rdv), 256'(288));
    chk("t4_busy3", 256'(busy[3]), 256'(0));
    wr(3, 7, 64'd0);
    rd(3, 6, rdv);
    chk("t4_clr", 256'(rdv), 256'(32));

    // 5: key write while busy, words rewrite mid-job
    do_reset();
    wr(0, 0, 64'h1111);
    wr(0, 4, 64'd10);
    chk("t5_busy", 256'(busy[0]), 256'(1));
    wr(0, 0, 64'h2222);
    rd(0, 6, rdv);
    chk("t5_errkey", 256'(rdv), 256'(160));
    issue_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_iss("t5_pre", 0, i, 256'(64'h1111));
    end
    wr(0, 4, 64'd2);
    chk("t5_wr_wins", 256'(issue_valid), 256'(0));
    for (int i = 0; i < 2; i++) begin
      step();
      chk_iss("t5_post", 0, i, 256'(64'h1111));
    end
    step();
    chk("t5_stop", 256'(issue_valid), 256'(0));
    issue_ready = 1'b0;
    rd(0, 5, rdv);
    chk("t5_issued", 256'(rdv), 256'(5));

    // 6: reset mid-job, then no issues without ready
    do_reset();
    issue_ready = 1'b1;
    wr(2, 4, 64'd10);
    step();
    chk("t6_pre", 256'(issue_valid), 256'(1));
    rst = 1'b1;
    step();
    chk("t6_valid", 256'(issue_valid), 256'(0));
    chk("t6_ctx", 256'(issue_ctx), 256'(0));
    chk("t6_seq", 256'(issue_seq), 256'(0));
    chk("t6_key", issue_key, 256'(0));
    chk("t6_resp", 256'(resp), 256'(0));
    rst         = 1'b0;
    issue_ready = 1'b0;
    step();
    chk("t6_busy", 256'(busy), 256'(0));
    rd(2, 4, rdv);
    chk("t6_words", 256'(rdv), 256'(0));
    rd(2, 5, rdv);
    chk("t6_issued", 256'(rdv), 256'(0));
    rd(2, 6, rdv);
    chk("t6_stat", 256'(rdv), 256'(32));
    wr(1, 4, 64'd5);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (issue_valid) cnt++;
    end
    chk("t6_noready", 256'(cnt), 256'(0));
    chk("t6_busy1", 256'(busy[1]), 256'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
